// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: programs a register-mapped UART, pushes transmit bytes into it
// and drains received bytes on interrupt, over a simple single-cycle register bus.
//
// state    | meaning
// UNCFG    | out of reset, UART not yet programmed
// WR_DIV   | writing the baud divider register
// WR_CTRL  | writing control (tx_en, rx_en, crc_en)
// READY    | idle: accepts a tx byte or services a pending rx interrupt
// RD_RX    | reading the RX data register
// RD_CAP   | capturing read data and presenting the received byte
// WR_TX    | writing the TX data register
// WR_START | writing control with tx_start set
// WAIT_TX  | waiting for the tx interrupt, bounded by TX_TIMEOUT
module uart_host_ctrl #(
    parameter logic [4:0]  ADDR_CTRL   = 5'h00,
    parameter logic [4:0]  ADDR_DIV    = 5'h04,
    parameter logic [4:0]  ADDR_TXDATA = 5'h08,
    parameter logic [4:0]  ADDR_RXDATA = 5'h0C,
    parameter logic [19:0] TX_TIMEOUT  = 20'hFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic [15:0] divider_i,
    input  logic        crc_en_i,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_err_o,
    input  logic        tx_int_i,
    input  logic        rx_int_i,
    input  logic        err_int_i,
    output logic        cfg_cs_o,
    output logic        cfg_we_o,
    output logic [4:0]  cfg_addr_o,
    output logic [31:0] cfg_data_o,
    input  logic [31:0] cfg_data_i,
    output logic        busy_o,
    output logic        tx_timeout_o,
    output logic        rx_ovr_o
);

    typedef enum logic [3:0] {
        UNCFG, WR_DIV, WR_CTRL, READY, RD_RX, RD_CAP, WR_TX, WR_START, WAIT_TX
    } state_t;

    state_t      state;
    logic        tx_prev, rx_prev, err_prev;
    logic        tx_pend, rx_pend, err_pend;
    logic        crc_en_reg;
    logic [19:0] tmo_cnt;
    logic        tx_edge, rx_edge, err_edge;
    logic        cfg_hi_unused;

    assign tx_edge  = tx_int_i  & ~tx_prev;
    assign rx_edge  = rx_int_i  & ~rx_prev;
    assign err_edge = err_int_i & ~err_prev;

    // Only the low byte of read data carries an RX character.
    assign cfg_hi_unused = ^cfg_data_i[31:8];

    // A same-cycle rx edge already blocks tx, so rx always wins the tie.
    assign tx_ready_o = (state == READY) && !rx_pend && !rx_edge;
    assign busy_o     = (state != UNCFG) && (state != READY);

    // Sequencer: bus access registers are loaded on the transition into the
    // state that owns the access, so each access is visible for that state's cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= UNCFG;
            tx_prev      <= 1'b0;
            rx_prev      <= 1'b0;
            err_prev     <= 1'b0;
            tx_pend      <= 1'b0;
            rx_pend      <= 1'b0;
            err_pend     <= 1'b0;
            crc_en_reg   <= 1'b0;
            tmo_cnt      <= '0;
            cfg_cs_o     <= 1'b0;
            cfg_we_o     <= 1'b0;
            cfg_addr_o   <= '0;
            cfg_data_o   <= '0;
            rx_valid_o   <= 1'b0;
            rx_data_o    <= '0;
            rx_err_o     <= 1'b0;
            tx_timeout_o <= 1'b0;
            rx_ovr_o     <= 1'b0;
        end else begin
            tx_prev      <= tx_int_i;
            rx_prev      <= rx_int_i;
            err_prev     <= err_int_i;
            cfg_cs_o     <= 1'b0;
            cfg_we_o     <= 1'b0;
            cfg_addr_o   <= '0;
            cfg_data_o   <= '0;
            rx_valid_o   <= 1'b0;
            tx_timeout_o <= 1'b0;
            rx_ovr_o     <= rx_edge & rx_pend;

            case (state)
                UNCFG, READY: begin
                    if (init_i) begin
                        state      <= WR_DIV;
                        cfg_cs_o   <= 1'b1;
                        cfg_we_o   <= 1'b1;
                        cfg_addr_o <= ADDR_DIV;
                        cfg_data_o <= {16'h0, divider_i};
                    end else if (state == READY) begin
                        if (rx_pend || rx_edge) begin
                            state      <= RD_RX;
                            cfg_cs_o   <= 1'b1;
                            cfg_addr_o <= ADDR_RXDATA;
                        end else if (tx_valid_i) begin
                            state      <= WR_TX;
                            tx_pend    <= 1'b0;
                            cfg_cs_o   <= 1'b1;
                            cfg_we_o   <= 1'b1;
                            cfg_addr_o <= ADDR_TXDATA;
                            cfg_data_o <= {24'h0, tx_data_i};
                        end
                    end
                end
                WR_DIV: begin
                    state      <= WR_CTRL;
                    crc_en_reg <= crc_en_i;
                    cfg_cs_o   <= 1'b1;
                    cfg_we_o   <= 1'b1;
                    cfg_addr_o <= ADDR_CTRL;
                    cfg_data_o <= {28'h0, 1'b0, crc_en_i, 2'b11};
                end
                WR_CTRL: state <= READY;
                RD_RX: begin
                    state   <= RD_CAP;
                    rx_pend <= 1'b0;
                end
                RD_CAP: begin
                    state      <= READY;
                    rx_data_o  <= cfg_data_i[7:0];
                    rx_valid_o <= 1'b1;
                    rx_err_o   <= err_pend;
                    err_pend   <= 1'b0;
                end
                WR_TX: begin
                    state      <= WR_START;
                    cfg_cs_o   <= 1'b1;
                    cfg_we_o   <= 1'b1;
                    cfg_addr_o <= ADDR_CTRL;
                    cfg_data_o <= {28'h0, 1'b1, crc_en_reg, 2'b11};
                end
                WR_START: begin
                    state   <= WAIT_TX;
                    tmo_cnt <= '0;
                end
                WAIT_TX: begin
                    if (tx_pend) begin
                        state   <= READY;
                        tx_pend <= 1'b0;
                    end else if (tmo_cnt == TX_TIMEOUT - 20'd1) begin
                        state        <= READY;
                        tx_timeout_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end
                default: state <= UNCFG;
            endcase

            // New interrupt edges win over same-cycle clears so none is lost.
            if (tx_edge)  tx_pend  <= 1'b1;
            if (rx_edge)  rx_pend  <= 1'b1;
            if (err_edge) err_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: directed and randomized checks of uart_host_ctrl against a
// transaction-level expectation of bus accesses, received bytes and status pulses.
module tb_uart_host_ctrl;

    localparam logic [4:0]  A_CTRL = 5'h00;
    localparam logic [4:0]  A_DIV  = 5'h04;
    localparam logic [4:0]  A_TX   = 5'h08;
    localparam logic [4:0]  A_RX   = 5'h0C;
    localparam logic [19:0] TMO    = 20'd20;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        init_i = 1'b0;
    logic [15:0] divider_i = '0;
    logic        crc_en_i = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_data_i = '0;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_err_o;
    logic        tx_int_i = 1'b0;
    logic        rx_int_i = 1'b0;
    logic        err_int_i = 1'b0;
    logic        cfg_cs_o;
    logic        cfg_we_o;
    logic [4:0]  cfg_addr_o;
    logic [31:0] cfg_data_o;
    logic [31:0] cfg_data_i = 32'hDEAD_BEEF;
    logic        busy_o;
    logic        tx_timeout_o;
    logic        rx_ovr_o;

    uart_host_ctrl #(.TX_TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .init_i(init_i), .divider_i(divider_i),
        .crc_en_i(crc_en_i), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
        .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
        .rx_err_o(rx_err_o), .tx_int_i(tx_int_i), .rx_int_i(rx_int_i),
        .err_int_i(err_int_i), .cfg_cs_o(cfg_cs_o), .cfg_we_o(cfg_we_o),
        .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_data_i(cfg_data_i),
        .busy_o(busy_o), .tx_timeout_o(tx_timeout_o), .rx_ovr_o(rx_ovr_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed bus accesses {we, addr, data} with the cycle they occurred in.
    logic [37:0] bus_q[$];
    int          bus_cyc[$];
    int          cyc = 0;
    int          n_tmo = 0, n_ovr = 0, idle_bad = 0;
    int          exp_tmo = 0, exp_ovr = 0;
    int          n_cmp = 0, n_err = 0;
    logic        m_crc = 1'b0;

    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (cfg_cs_o) begin
            bus_q.push_back({cfg_we_o, cfg_addr_o, cfg_data_o});
            bus_cyc.push_back(cyc);
        end else if (cfg_we_o || cfg_addr_o != 5'h0 || cfg_data_o != 32'h0) begin
            idle_bad = idle_bad + 1;
        end
        if (tx_timeout_o) n_tmo = n_tmo + 1;
        if (rx_ovr_o) n_ovr = n_ovr + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pop_acc(input string tag, input logic [37:0] exp, output int c);
        logic [37:0] got;
        for (int i = 0; i < 40 && bus_q.size() == 0; i++) step();
        got = '1;
        c = -1;
        if (bus_q.size() > 0) begin
            got = bus_q.pop_front();
            c = bus_cyc.pop_front();
        end
        check(tag, {26'h0, got}, {26'h0, exp});
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy_o; i++) step();
        check(tag, busy_o, 1'b0);
    endtask

    task automatic do_init(input logic [15:0] div, input logic crc);
        int c0, c1;
        divider_i = div;
        crc_en_i = crc;
        init_i = 1'b1;
        step();
        init_i = 1'b0;
        m_crc = crc;
        pop_acc("init_div", {1'b1, A_DIV, 16'h0, div}, c0);
        pop_acc("init_ctrl", {1'b1, A_CTRL, 28'h0, 1'b0, crc, 2'b11}, c1);
        check("init_consecutive", c1 - c0, 1);
        wait_idle("init_idle");
        check("init_tx_ready", tx_ready_o, 1'b1);
    endtask

    // Leaves the bench in the first WAIT_TX cycle when the DUT behaves.
    task automatic start_tx(input logic [7:0] b);
        int c;
        for (int i = 0; i < 40 && !tx_ready_o; i++) step();
        tx_valid_i = 1'b1;
        tx_data_i = b;
        step();
        tx_valid_i = 1'b0;
        tx_data_i = 8'($urandom);
        pop_acc("tx_data_wr", {1'b1, A_TX, 24'h0, b}, c);
        pop_acc("tx_start_wr", {1'b1, A_CTRL, 28'h0, 1'b1, m_crc, 2'b11}, c);
    endtask

    task automatic finish_tx();
        int dly;
        dly = int'($urandom_range(0, 5));
        for (int i = 0; i < dly; i++) step();
        tx_int_i = 1'b1;
        step();
        tx_int_i = 1'b0;
        wait_idle("tx_done_idle");
        check("tx_no_timeout", n_tmo, exp_tmo);
    endtask

    task automatic rx_read(input logic [7:0] d, input logic e, input string tag);
        logic [31:0] rnd;
        int c;
        wait_idle({tag, "_pre"});
        rx_int_i = 1'b1;
        step();
        rx_int_i = 1'b0;
        check({tag, "_busy"}, {busy_o, tx_ready_o}, 2'b10);
        step();
        rnd = $urandom;
        cfg_data_i = {rnd[31:8], d};
        step();
        cfg_data_i = $urandom;
        check({tag, "_byte"}, {rx_valid_o, rx_err_o, rx_data_o}, {1'b1, e, d});
        pop_acc({tag, "_rd"}, {1'b0, A_RX, 32'h0}, c);
        step();
        check({tag, "_pulse"}, rx_valid_o, 1'b0);
    endtask

    task automatic pulse_err();
        err_int_i = 1'b1;
        step();
        err_int_i = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0]  b, d;
        logic [31:0] rnd;
        logic        e;
        int          op, c, k;

        #2 rst_i = 1'b0;
        step();
        step();
        check("reset_outputs",
              {tx_ready_o, rx_valid_o, rx_data_o, rx_err_o, tx_timeout_o, rx_ovr_o,
               busy_o, cfg_cs_o, cfg_we_o, cfg_addr_o, cfg_data_o}, 64'h0);
        rst_i = 1'b1;
        step();
        check("uncfg_not_ready", {busy_o, tx_ready_o}, 2'b00);

        do_init(16'h0036, 1'b1);

        start_tx(8'hA5);
        finish_tx();

        rx_read(8'h3C, 1'b0, "rx_3c");

        pulse_err();
        rx_read($urandom, 1'b1, "rx_err1");
        rx_read($urandom, 1'b0, "rx_err0");

        // rx and tx requested together: read first, tx held off until it completes
        wait_idle("col_pre");
        b = $urandom;
        d = $urandom;
        rx_int_i = 1'b1;
        tx_valid_i = 1'b1;
        tx_data_i = b;
        step();
        rx_int_i = 1'b0;
        check("col_ready_low_rd", tx_ready_o, 1'b0);
        step();
        check("col_ready_low_cap", tx_ready_o, 1'b0);
        rnd = $urandom;
        cfg_data_i = {rnd[31:8], d};
        step();
        cfg_data_i = $urandom;
        check("col_rx_byte", {rx_valid_o, rx_err_o, rx_data_o}, {1'b1, 1'b0, d});
        step();
        tx_valid_i = 1'b0;
        pop_acc("col_read_first", {1'b0, A_RX, 32'h0}, c);
        pop_acc("col_tx_data", {1'b1, A_TX, 24'h0, b}, c);
        pop_acc("col_tx_start", {1'b1, A_CTRL, 28'h0, 1'b1, m_crc, 2'b11}, c);
        finish_tx();

        // no tx interrupt: timeout pulse TMO cycles after entering WAIT_TX
        start_tx($urandom);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (tx_timeout_o) begin
                k = i;
                break;
            end
        end
        exp_tmo = exp_tmo + 1;
        check("timeout_latency", k, int'(TMO));
        check("timeout_ready", busy_o, 1'b0);
        step();
        check("timeout_pulse_end", tx_timeout_o, 1'b0);

        // second rx edge while one is still pending flags an overrun
        start_tx($urandom);
        rx_int_i = 1'b1;
        step();
        rx_int_i = 1'b0;
        step();
        check("ovr_first_edge", rx_ovr_o, 1'b0);
        rx_int_i = 1'b1;
        step();
        rx_int_i = 1'b0;
        exp_ovr = exp_ovr + 1;
        check("ovr_pulse", rx_ovr_o, 1'b1);
        step();
        check("ovr_pulse_end", rx_ovr_o, 1'b0);
        d = $urandom;
        cfg_data_i = {24'h0, d};
        tx_int_i = 1'b1;
        step();
        tx_int_i = 1'b0;
        for (int i = 0; i < 20 && !rx_valid_o; i++) step();
        check("ovr_rx_byte", {rx_valid_o, rx_err_o, rx_data_o}, {1'b1, 1'b0, d});
        cfg_data_i = $urandom;
        pop_acc("ovr_rx_rd", {1'b0, A_RX, 32'h0}, c);
        wait_idle("ovr_idle");

        for (int it = 0; it < 12; it++) begin
            op = int'($urandom_range(0, 2));
            crc_en_i = 1'($urandom_range(0, 1));
            if (op == 0) begin
                start_tx($urandom);
                finish_tx();
            end else if (op == 1) begin
                d = $urandom;
                e = 1'($urandom_range(0, 1));
                if (e) pulse_err();
                rx_read(d, e, "rnd_rx");
            end else begin
                do_init(16'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        // reset mid-transaction with an rx interrupt pending
        start_tx($urandom);
        rx_int_i = 1'b1;
        step();
        rx_int_i = 1'b0;
        step();
        rst_i = 1'b0;
        #1;
        check("rst_wait_tx_outputs",
              {tx_ready_o, rx_valid_o, rx_data_o, rx_err_o, tx_timeout_o, rx_ovr_o,
               busy_o, cfg_cs_o, cfg_we_o, cfg_addr_o, cfg_data_o}, 64'h0);
        step();
        step();
        rst_i = 1'b1;
        tx_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rst_uncfg", {busy_o, tx_ready_o}, 2'b00);
        tx_valid_i = 1'b0;
        check("rst_no_access", bus_q.size(), 0);
        do_init(16'h1234, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("rst_rx_pend_cleared", {bus_q.size(), rx_valid_o}, 0);

        // crc_en_i changes after init must not reach the start command
        crc_en_i = 1'b1;
        start_tx(8'h5A);
        finish_tx();

        check("timeout_count", n_tmo, exp_tmo);
        check("overrun_count", n_ovr, exp_ovr);
        check("idle_bus_zero", idle_bad, 0);
        check("no_extra_access", bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_host_ctrl.md
UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter ADDR_CTRL, default 5'h00: control register address (bit0 tx_en, bit1 rx_en, bit2 crc_en, bit3 tx_start).
REQ-002 SHALL have parameter ADDR_DIV, default 5'h04: clock divider register address (bits 15:0).
REQ-003 SHALL have parameter ADDR_TXDATA, default 5'h08: TX data register address (bits 7:0).
REQ-004 SHALL have parameter ADDR_RXDATA, default 5'h0C: RX data register address (bits 7:0).
REQ-005 SHALL have parameter TX_TIMEOUT, default 20'hFFFFF: maximum cycles spent waiting for tx_int_i.
REQ-006 SHALL have clk_i  input  1  single clock; all logic is rising-edge.
REQ-007 SHALL have rst_i  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have init_i  input  1  one-cycle request to program the UART.
REQ-009 SHALL have divider_i  input  16  baud divider value written on init.
REQ-010 SHALL have crc_en_i  input  1  CRC enable value written on init.
REQ-011 SHALL have tx_valid_i / tx_data_i / tx_ready_o  in/in/out  1/8/1  byte-to-send handshake.
REQ-012 SHALL have rx_valid_o / rx_data_o / rx_err_o  out  1/8/1  received-byte pulse, data, error flag.
REQ-013 SHALL have tx_int_i / rx_int_i / err_int_i  input  1 each  UART interrupt lines.
REQ-014 SHALL have cfg_cs_o / cfg_we_o / cfg_addr_o / cfg_data_o  out  1/1/5/32  register-bus master outputs; cfg_data_i  input  32  read data.
REQ-015 SHALL have busy_o / tx_timeout_o / rx_ovr_o  out  1 each  status, timeout pulse, overrun pulse.

Function
REQ-016 SHALL implement states UNCFG, WR_DIV, WR_CTRL, READY, RD_RX, RD_CAP, WR_TX, WR_START, WAIT_TX.
REQ-017 SHALL, on init_i in UNCFG or READY, go to WR_DIV; init_i in any other state is ignored.
REQ-018 SHALL, in WR_DIV, drive cs=1, we=1, addr=ADDR_DIV, data={16'h0,divider_i} for exactly one cycle, then go to WR_CTRL.
REQ-019 SHALL, in WR_CTRL, write ADDR_CTRL with data={28'h0,0,crc_en_i,1,1} for one cycle, then go to READY.
REQ-020 SHALL drive cfg_cs_o=0, cfg_we_o=0 and hold cfg_addr_o/cfg_data_o at 0 in every state not issuing an access.
REQ-021 SHALL detect rising edges of tx_int_i, rx_int_i and err_int_i (one registered previous value each) and latch them into sticky flags tx_pend, rx_pend, err_pend.
REQ-022 SHALL, in READY with rx_pend=1, go to RD_RX; rx has priority over tx when both are possible in the same cycle.
REQ-023 SHALL, in RD_RX, issue a one-cycle read (cs=1, we=0, addr=ADDR_RXDATA), clear rx_pend, then go to RD_CAP.
REQ-024 SHALL, in RD_CAP, capture cfg_data_i[7:0] into rx_data_o, pulse rx_valid_o for one cycle with rx_err_o=err_pend, clear err_pend, then go to READY.
REQ-025 SHALL, on an rx_int_i rising edge while rx_pend is already 1, pulse rx_ovr_o for one cycle; the flag stays 1.
REQ-026 SHALL drive tx_ready_o=1 only in READY with rx_pend=0; a transfer occurs when tx_valid_i and tx_ready_o are both 1.
REQ-027 SHALL, on a tx transfer, clear tx_pend, register tx_data_i, and go to WR_TX.
REQ-028 SHALL, in WR_TX, write ADDR_TXDATA with {24'h0,byte} for one cycle, then go to WR_START.
REQ-029 SHALL, in WR_START, write ADDR_CTRL with {28'h0,1,crc_en_reg,1,1} for one cycle, then go to WAIT_TX.
REQ-030 SHALL, in WAIT_TX, return to READY when tx_pend=1, clearing tx_pend in the same cycle.
REQ-031 SHALL count WAIT_TX cycles with a 20-bit counter cleared on entry; on reaching TX_TIMEOUT, pulse tx_timeout_o for one cycle and return to READY.
REQ-032 SHALL register crc_en_i at init into crc_en_reg; it is not sampled outside WR_CTRL.
REQ-033 SHALL drive busy_o=1 in every state except UNCFG and READY.

Reset
REQ-034 SHALL, while rst_i=0, force state UNCFG; clear all pending flags, edge registers, the counter and crc_en_reg; and drive all outputs to 0, including mid-transaction.

Verification
REQ-035 SHALL be verified as follows: init_i with divider_i=16'h0036 and crc_en_i=1 -> write DIV 32'h36, then write CTRL 32'h7 on consecutive cycles, then tx_ready_o=1.
REQ-036 SHALL be verified as follows: in READY, tx byte 8'hA5 -> TXDATA write 32'hA5, then CTRL write 32'hF; tx_int_i pulse -> READY.
REQ-037 SHALL be verified as follows: rx_int_i pulse with cfg_data_i=32'h3C on the cycle after the read -> rx_valid_o pulse with rx_data_o=8'h3C and rx_err_o=0.
REQ-038 SHALL be verified as follows: err_int_i pulse, then rx_int_i pulse -> next rx_valid_o carries rx_err_o=1; the following byte carries rx_err_o=0.
REQ-039 SHALL be verified as follows: rx_int_i and tx_valid_i asserted in the same READY cycle -> RD_RX first, tx_ready_o=0 until the read completes.
REQ-040 SHALL be verified as follows: with TX_TIMEOUT=20 and no tx_int_i -> tx_timeout_o pulse 20 cycles after entering WAIT_TX; rst_i=0 in WAIT_TX -> all outputs 0 and state UNCFG.
